// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin or fixed-priority N:1 arbiter feeding a registered output stage
module rr_arb_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int MODE     = 0,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_sel,
    input  logic                      out_ready
);
    logic            out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0] out_sel_q, out_sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] start_idx, gnt_idx;
    logic            gnt_any, free, take;
    assign free      = !out_valid_q || out_ready;
    assign start_idx = (MODE == 0) ? ptr_q : '0;
    // Scan backwards so the last hit is the first valid channel in search order
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (in_valid[(int'(start_idx) + k) % CHANNELS]) begin
                gnt_any = 1'b1;
                gnt_idx = SELW'((int'(start_idx) + k) % CHANNELS);
            end
        end
    end
    assign take     = rst_n && free && gnt_any;
    assign in_ready = take ? (CHANNELS'(1) << gnt_idx) : '0;
    always_comb begin
        out_valid_d = free ? gnt_any : out_valid_q;
        out_data_d  = take ? in_data[int'(gnt_idx)*WIDTH +: WIDTH] : out_data_q;
        out_sel_d   = take ? gnt_idx : out_sel_q;
        ptr_d       = (take && MODE == 0)
                    ? ((int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + SELW'(1))
                    : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed vectors against a round-robin and a fixed-priority instance
module tb_rr_arb_mux;
    localparam int W = 16;
    localparam int N = 16;
    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           out_ready;
    logic [N-1:0]   rdy0, rdy1;
    logic           ov0, ov1;
    logic [W-1:0]   od0, od1;
    logic [3:0]     os0, os1;
    int             n_vec = 0;
    int             n_err = 0;
    always #5 clk = ~clk;
    rr_arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(out_ready)
    );
    rr_arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(out_ready)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [W-1:0] dat(input int i);
        return (i == 5) ? 16'hA5A5 : (16'hC000 | 16'(i));
    endfunction
    initial begin
        rst_n     = 1'b0;
        in_valid  = 16'hFFFF;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = dat(i);
        step();
        step();
        chk("rst_in_ready", rdy0, 0);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", od0, 0);
        chk("rst_out_sel", os0, 0);
        rst_n    = 1'b1;
        in_valid = 16'h0020;
        #1;
        chk("single_in_ready", rdy0, 16'h0020);
        step();
        chk("single_valid", ov0, 1);
        chk("single_data", od0, 16'hA5A5);
        chk("single_sel", os0, 5);
        // Hold a word under backpressure, then reset: it must vanish and ptr return to 0
        in_valid  = 16'h0000;
        out_ready = 1'b0;
        step();
        chk("hold_valid", ov0, 1);
        rst_n = 1'b0;
        in_valid = 16'hFFFF;
        #1;
        chk("rst_mid_in_ready", rdy0, 0);
        step();
        chk("rst_mid_valid", ov0, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rr_first_grant", rdy0, 16'h0001);
        for (int i = 0; i <= N; i++) begin
            step();
            chk("rr_sel", os0, i % N);
            chk("rr_data", od0, dat(i % N));
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", rdy0, 0);
            step();
            chk("bp_valid", ov0, 1);
            chk("bp_sel", os0, 0);
            chk("bp_data", od0, dat(0));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_grant", rdy0, 16'h0002);
        step();
        chk("bp_release_sel", os0, 1);
        in_valid = 16'h2000;
        step();
        chk("wrap_sel13", os0, 13);
        in_valid = 16'h0003;
        #1;
        chk("wrap_grant0", rdy0, 16'h0001);
        step();
        chk("wrap_sel0", os0, 0);
        chk("wrap_grant1", rdy0, 16'h0002);
        step();
        chk("wrap_sel1", os0, 1);
        in_valid = 16'h0000;
        #1;
        chk("idle_in_ready", rdy0, 0);
        step();
        chk("idle_valid", ov0, 0);
        chk("idle_sel_kept", os0, 1);
        chk("idle_data_kept", od0, dat(1));
        in_valid = 16'h0018;
        #1;
        chk("fp_grant", rdy1, 16'h0008);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fp_sel", os1, 3);
            chk("fp_data", od1, dat(3));
            chk("fp_valid", ov1, 1);
        end
        chk("rr_alt_after_fp", os0, 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 16, number of input channels (2..64).
REQ-003 SHALL have parameter MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 SHALL have derived parameter SELW = ceil(log2(CHANNELS)), default 4, the select width.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-008 SHALL have port in_valid  input  CHANNELS  bit i means channel i offers data.
REQ-009 SHALL have port in_data  input  CHANNELS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port in_ready  output  CHANNELS  one-hot or zero; bit i means channel i is accepted this cycle.
REQ-011 SHALL have port out_valid  output  1  the output register holds a word.
REQ-012 SHALL have port out_data  output  WIDTH  the registered word.
REQ-013 SHALL have port out_sel  output  SELW  the channel index the word came from.
REQ-014 SHALL have port out_ready  input  1  the consumer accepts the word this cycle.

Function
REQ-015 SHALL define free = !out_valid | out_ready, evaluated combinationally each cycle.
REQ-016 SHALL, when free and in_valid != 0, grant exactly one channel g and drive in_ready = (1 << g) in the same cycle; otherwise in_ready = 0.
REQ-017 SHALL compute in_ready only from in_valid, out_valid, out_ready and internal state; it SHALL NOT depend on in_data.
REQ-018 SHALL, on a grant, load out_data = in_data[g], out_sel = g and out_valid = 1 at the next edge (1-cycle latency).
REQ-019 SHALL, when free and in_valid == 0, clear out_valid at the next edge; out_data and out_sel keep their last values.
REQ-020 SHALL, when out_valid = 1 and out_ready = 0, hold out_valid, out_data and out_sel stable and keep in_ready = 0.
REQ-021 SHALL sustain one transfer per cycle while out_ready = 1 and any in_valid is set.
REQ-022 SHALL, in MODE 0, keep a pointer ptr (SELW bits) and grant the first valid channel searching ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1.
REQ-023 SHALL, in MODE 0, set ptr = g+1 after each grant, wrapping from CHANNELS-1 to 0 (also for non-power-of-2 CHANNELS).
REQ-024 SHALL, in MODE 0, leave ptr unchanged in any cycle without a grant.
REQ-025 SHALL, in MODE 1, grant the lowest-index valid channel; ptr is unused.
REQ-026 SHALL ignore a channel that drops in_valid without being granted; no state records it.

Reset
REQ-027 SHALL, while rst_n = 0 at a clock edge, set out_valid = 0, out_data = 0, out_sel = 0 and ptr = 0.
REQ-028 SHALL force in_ready = 0 while rst_n = 0, regardless of the other inputs.
REQ-029 SHALL discard any held word when reset is asserted mid-transfer; the word is not presented after reset.
REQ-030 SHALL resume arbitration from ptr = 0 in the first cycle after rst_n returns to 1.

Verification
REQ-031 SHALL cover reset: rst_n = 0 for 2 cycles, in_valid = 16'hFFFF -> in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0.
REQ-032 SHALL cover a single channel: in_valid = 16'h0020, in_data[5] = 16'hA5A5, out_ready = 1 -> in_ready = 16'h0020 the same cycle; next cycle out_valid = 1, out_data = 16'hA5A5, out_sel = 5.
REQ-033 SHALL cover round-robin fairness: MODE 0, in_valid = 16'hFFFF held, out_ready = 1 -> out_sel = 0,1,...,15,0 on consecutive cycles.
REQ-034 SHALL cover backpressure: out_valid = 1, out_ready = 0 for 3 cycles -> out_data/out_sel stable, in_ready = 0; on out_ready = 1 a new grant occurs the same cycle.
REQ-035 SHALL cover pointer wrap: MODE 0, grant to channel 13 (ptr = 14), then in_valid = 16'h0003 -> grants 0, then 1.
REQ-036 SHALL cover fixed priority: MODE 1, in_valid = 16'h0018 held, out_ready = 1 -> out_sel = 3 every cycle.
